pixel_write_arbiter: RTL



---
 rtl/pixel_write_arbiter_pkg.sv | 21 ++
 rtl/pixel_fifo.sv | 67 ++++++
 rtl/pixel_write_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pixel_write_arbiter_pkg.sv
// Shared screen geometry and pixel type for the pixel write arbiter.
// Used by pixel_write_arbiter and pixel_fifo.
package pixel_write_arbiter_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 3;

    // One pixel write as seen by the VGA adapter: {x, y, colour}, 18 bits.
    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    localparam int unsigned PIXEL_W = $bits(pixel_t);

endpackage : pixel_write_arbiter_pkg

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with push/pop, full/empty flags and an occupancy count.
// Push is ignored while full and pop is ignored while empty; the read port
// shows the head entry combinationally.
module pixel_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == {CW{1'b0}});
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Qualify requests against the flags and compute next pointers/count.
    always_comb begin
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
        wr_ptr_d  = push_ok_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d  = pop_ok_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards all contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; entries are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule : pixel_fifo

// File: rtl/pixel_write_arbiter.sv
// Pixel write arbiter in front of the 160x120 VGA adapter.
// Accepts pixels from the background and object drawers (valid/ready),
// arbitrates, clips off-screen pixels, buffers them in pixel_fifo and drains
// one pixel per clock into registered plot/vga_* outputs.
// Build option: PIXARB_ROUND_ROBIN_EN selects round-robin arbitration
// instead of fixed background priority.
module pixel_write_arbiter
    import pixel_write_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned X_MAX      = SCREEN_W,
    parameter int unsigned Y_MAX      = SCREEN_H
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                bg_valid,
    input  logic [X_W-1:0]      bg_x,
    input  logic [Y_W-1:0]      bg_y,
    input  logic [COLOUR_W-1:0] bg_colour,
    output logic                bg_ready,
    input  logic                obj_valid,
    input  logic [X_W-1:0]      obj_x,
    input  logic [Y_W-1:0]      obj_y,
    input  logic [COLOUR_W-1:0] obj_colour,
    output logic                obj_ready,
    output logic                plot,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                fifo_empty,
    output logic [7:0]          drop_count
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             full_s, empty_s;
    logic [CNT_W-1:0] count_s;
    pixel_t           rd_px_s, acc_px_s;
    logic             accept_s, clip_s, push_s, pop_s;

    logic             plot_q, plot_d;
    pixel_t           vga_q, vga_d;
    logic [7:0]       drop_q, drop_d;

`ifdef PIXARB_ROUND_ROBIN_EN
    // prio_obj_q marks which source wins the next contention; it starts with
    // the object drawer and flips to the other source after every grant.
    logic prio_obj_q, prio_obj_d;

    // Round-robin ready: a source loses only if the other is valid and holds priority.
    always_comb begin
        bg_ready  = !full_s && !(obj_valid && prio_obj_q);
        obj_ready = !full_s && !(bg_valid && !prio_obj_q);
    end

    // Hand priority to the source that was not just granted.
    always_comb begin
        if (bg_valid && bg_ready) begin
            prio_obj_d = 1'b1;
        end else if (obj_valid && obj_ready) begin
            prio_obj_d = 1'b0;
        end else begin
            prio_obj_d = prio_obj_q;
        end
    end

    // Priority register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            prio_obj_q <= 1'b1;
        end else begin
            prio_obj_q <= prio_obj_d;
        end
    end
`else
    // Fixed priority: background always wins, object only when background idle.
    always_comb begin
        bg_ready  = !full_s;
        obj_ready = !full_s && !bg_valid;
    end
`endif

    // Select the accepted pixel and decide whether it is buffered or clipped.
    always_comb begin
        accept_s = 1'b0;
        acc_px_s = '0;
        if (bg_valid && bg_ready) begin
            accept_s = 1'b1;
            acc_px_s = {bg_x, bg_y, bg_colour};
        end else if (obj_valid && obj_ready) begin
            accept_s = 1'b1;
            acc_px_s = {obj_x, obj_y, obj_colour};
        end else begin
            accept_s = 1'b0;
            acc_px_s = '0;
        end
        clip_s = accept_s && ((32'(acc_px_s.x) >= X_MAX) || (32'(acc_px_s.y) >= Y_MAX));
        push_s = accept_s && !clip_s;
    end

    // The adapter has no back-pressure, so drain whenever anything is buffered.
    assign pop_s = !empty_s;

    pixel_fifo #(
        .WIDTH (PIXEL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clock),
        .rst   (Reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (acc_px_s),
        .rdata (rd_px_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Next output state: load on pop, otherwise hold coordinates and drop the strobe.
    always_comb begin
        if (pop_s) begin
            plot_d = 1'b1;
            vga_d  = rd_px_s;
        end else begin
            plot_d = 1'b0;
            vga_d  = vga_q;
        end
    end

    // Saturating count of clipped pixels.
    always_comb begin
        if (clip_s && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Output and drop-counter registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            plot_q <= 1'b0;
            vga_q  <= '0;
            drop_q <= 8'd0;
        end else begin
            plot_q <= plot_d;
            vga_q  <= vga_d;
            drop_q <= drop_d;
        end
    end

    assign plot       = plot_q;
    assign vga_x      = vga_q.x;
    assign vga_y      = vga_q.y;
    assign vga_colour = vga_q.colour;
    assign drop_count = drop_q;
    assign fifo_empty = (count_s == {CNT_W{1'b0}}) && !plot_q;

endmodule : pixel_write_arbiter
